// File: rtl/scaler_pkg.sv
// Shared types and placement helpers for the pixel scaler.
// Offsets are constant functions of the geometry, so they fold away at elaboration.
package scaler_pkg;

  typedef enum logic {
    MODE_CENTRE  = 1'b0,
    MODE_TOPLEFT = 1'b1
  } mode_e;

  function automatic int x_off(input mode_e m, input int width, input int src_w,
                               input int scale_x);
    return (m == MODE_TOPLEFT) ? 0 : (width - src_w * scale_x) / 2;
  endfunction

  function automatic int y_off(input mode_e m, input int height, input int src_h,
                               input int scale_y);
    return (m == MODE_TOPLEFT) ? 0 : (height - src_h * scale_y) / 2;
  endfunction

endpackage

// File: rtl/axis_scaler.sv
// One-axis replication counter: restarts on start, advances one sub-step on step.
// pos is the coordinate the current beat maps to (next-state value of the counter).
module axis_scaler #(
  parameter int SCALE = 2,
  parameter int SRC_N = 160,
  parameter int POS_W = (SRC_N > 1) ? $clog2(SRC_N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             start,
  input  logic             step,
  output logic [POS_W-1:0] pos
);

  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  if (POS_W < $clog2(SRC_N) || SCALE < 1) begin : g_bad_cfg
    $error("axis_scaler: POS_W too narrow for SRC_N or SCALE < 1");
  end

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [POS_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sub_d = sub_q;
    cnt_d = cnt_q;
    if (active) begin
      if (start) begin
        sub_d = '0;
        cnt_d = '0;
      end else if (step) begin
        // The window bound guarantees cnt never steps past SRC_N-1 here.
        if (sub_q == SUB_LAST) begin
          sub_d = '0;
          cnt_d = cnt_q + POS_W'(1);
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q <= '0;
      cnt_q <= '0;
    end else begin
      sub_q <= sub_d;
      cnt_q <= cnt_d;
    end
  end

  assign pos = cnt_d;

endmodule

// File: rtl/pixel_scaler.sv
// Maps panel raster (hp, vp) to source pixel (hpos, vpos) with integer scaling,
// letterbox/top-left placement, line/frame strobes and a sticky sequence monitor.
module pixel_scaler
  import scaler_pkg::*;
#(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int SRC_W   = 160,
  parameter int SRC_H   = 120,
  parameter int SCALE_X = 2,
  parameter int SCALE_Y = 2,
  parameter int HPOS_W  = $clog2(SRC_W),
  parameter int VPOS_W  = $clog2(SRC_H)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_valid,
  input  logic [$clog2(WIDTH)-1:0]  hp,
  input  logic [$clog2(HEIGHT)-1:0] vp,
  input  logic                      mode,
  output logic                      out_valid,
  output logic [HPOS_W-1:0]         hpos,
  output logic [VPOS_W-1:0]         vpos,
  output logic                      in_window,
  output logic                      line_start,
  output logic                      frame_start,
  output logic                      seq_err
);

  // Flow: pix_valid marks a beat with no back-pressure; out_valid is that beat one
  // cycle later, and every other output holds its value while out_valid is low.

  localparam int HP_W = $clog2(WIDTH);
  localparam int VP_W = $clog2(HEIGHT);

  if (SRC_W * SCALE_X > WIDTH || SRC_H * SCALE_Y > HEIGHT) begin : g_bad_size
    $error("pixel_scaler: scaled source does not fit the panel");
  end

  localparam logic [HP_W:0] X_LO_C = (HP_W+1)'(x_off(MODE_CENTRE, WIDTH, SRC_W, SCALE_X));
  localparam logic [HP_W:0] X_LO_T = (HP_W+1)'(x_off(MODE_TOPLEFT, WIDTH, SRC_W, SCALE_X));
  localparam logic [HP_W:0] X_HI_C = X_LO_C + (HP_W+1)'(SRC_W * SCALE_X);
  localparam logic [HP_W:0] X_HI_T = X_LO_T + (HP_W+1)'(SRC_W * SCALE_X);
  localparam logic [VP_W:0] Y_LO_C = (VP_W+1)'(y_off(MODE_CENTRE, HEIGHT, SRC_H, SCALE_Y));
  localparam logic [VP_W:0] Y_LO_T = (VP_W+1)'(y_off(MODE_TOPLEFT, HEIGHT, SRC_H, SCALE_Y));
  localparam logic [VP_W:0] Y_HI_C = Y_LO_C + (VP_W+1)'(SRC_H * SCALE_Y);
  localparam logic [VP_W:0] Y_HI_T = Y_LO_T + (VP_W+1)'(SRC_H * SCALE_Y);

  logic [HP_W:0]   hp_x, x_lo, x_hi;
  logic [VP_W:0]   vp_y, y_lo, y_hi;
  logic            line_hit, frame_hit;
  logic            x_in, x_start, x_step;
  logic            y_in, y_start, y_step;
  mode_e           mode_eff;
  logic [HPOS_W-1:0] cx;
  logic [VPOS_W-1:0] cy;

  logic              out_valid_q, out_valid_d;
  logic [HPOS_W-1:0] hpos_q, hpos_d;
  logic [VPOS_W-1:0] vpos_q, vpos_d;
  logic              in_window_q, in_window_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic              seq_err_q, seq_err_d;
  logic              synced_q, synced_d;
  mode_e             mode_q, mode_d;
  logic [HP_W-1:0]   prev_hp_q, prev_hp_d;

  // A frame-start beat already uses the mode presented with it.
  always_comb begin
    hp_x      = {1'b0, hp};
    vp_y      = {1'b0, vp};
    line_hit  = (hp == '0);
    frame_hit = line_hit && (vp == '0);
    mode_eff  = frame_hit ? mode_e'(mode) : mode_q;
    x_lo      = (mode_eff == MODE_TOPLEFT) ? X_LO_T : X_LO_C;
    x_hi      = (mode_eff == MODE_TOPLEFT) ? X_HI_T : X_HI_C;
    y_lo      = (mode_eff == MODE_TOPLEFT) ? Y_LO_T : Y_LO_C;
    y_hi      = (mode_eff == MODE_TOPLEFT) ? Y_HI_T : Y_HI_C;
    x_in      = (hp_x >= x_lo) && (hp_x < x_hi);
    y_in      = (vp_y >= y_lo) && (vp_y < y_hi);
    x_start   = (hp_x == x_lo);
    y_start   = (vp_y == y_lo);
    x_step    = x_in && !x_start;
    y_step    = y_in && !y_start;
  end

  axis_scaler #(.SCALE(SCALE_X), .SRC_N(SRC_W), .POS_W(HPOS_W)) u_axis_x (
    .clk    (clk),
    .reset  (reset),
    .active (pix_valid),
    .start  (x_start),
    .step   (x_step),
    .pos    (cx)
  );

  axis_scaler #(.SCALE(SCALE_Y), .SRC_N(SRC_H), .POS_W(VPOS_W)) u_axis_y (
    .clk    (clk),
    .reset  (reset),
    .active (pix_valid && line_hit),
    .start  (y_start),
    .step   (y_step),
    .pos    (cy)
  );

  always_comb begin
    out_valid_d   = pix_valid;
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    in_window_d   = in_window_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    seq_err_d     = seq_err_q;
    synced_d      = synced_q;
    mode_d        = mode_q;
    prev_hp_d     = prev_hp_q;
    if (pix_valid) begin
      synced_d      = synced_q || frame_hit;
      mode_d        = mode_eff;
      line_start_d  = line_hit;
      frame_start_d = frame_hit;
      in_window_d   = synced_d && x_in && y_in;
      hpos_d        = in_window_d ? cx : '0;
      vpos_d        = in_window_d ? cy : '0;
      seq_err_d     = seq_err_q ||
                      (!line_hit && (hp_x != ({1'b0, prev_hp_q} + (HP_W+1)'(1))));
      prev_hp_d     = hp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      in_window_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      seq_err_q     <= 1'b0;
      synced_q      <= 1'b0;
      mode_q        <= MODE_CENTRE;
      prev_hp_q     <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      in_window_q   <= in_window_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      seq_err_q     <= seq_err_d;
      synced_q      <= synced_d;
      mode_q        <= mode_d;
      prev_hp_q     <= prev_hp_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign in_window   = in_window_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_pixel_scaler.sv
// Bench for pixel_scaler: three geometries driven by one shared raster stream,
// checked by a closed-form reference model plus spot-check tables and corner sequences.
module tb_pixel_scaler;

  typedef struct packed {
    logic       ov;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       iw;
    logic       ls;
    logic       fs;
    logic       se;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);
  localparam int QW    = 3 * OBS_W + 1;

  typedef struct {
    int dut;
    int mode;
    int hp;
    int vp;
    int e_hpos;
    int e_vpos;
    int e_iw;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic [8:0] hp = '0;
  logic [7:0] vp = '0;
  logic       mode = 1'b0;

  logic       out_valid_a, in_window_a, line_start_a, frame_start_a, seq_err_a;
  logic [7:0] hpos_a;
  logic [6:0] vpos_a;
  logic       out_valid_b, in_window_b, line_start_b, frame_start_b, seq_err_b;
  logic [6:0] hpos_b;
  logic [6:0] vpos_b;
  logic       out_valid_c, in_window_c, line_start_c, frame_start_c, seq_err_c;
  logic [6:0] hpos_c;
  logic [7:0] vpos_c;

  int total = 0;
  int bad   = 0;

  // reference model state
  int   cfg_sw [3] = '{160, 128, 100};
  int   cfg_sh [3] = '{120, 96, 240};
  int   cfg_sx [3] = '{2, 2, 3};
  int   cfg_sy [3] = '{2, 2, 1};
  obs_t m_exp [3];
  logic m_synced, m_mode, m_seq, m_trust;
  int   m_prev;
  logic [QW-1:0] exp_q[$];

  vec_t vecs [15];

  always #5 clk = ~clk;

  pixel_scaler u_dut_a (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .hp(hp), .vp(vp), .mode(mode),
    .out_valid(out_valid_a), .hpos(hpos_a), .vpos(vpos_a), .in_window(in_window_a),
    .line_start(line_start_a), .frame_start(frame_start_a), .seq_err(seq_err_a)
  );

  pixel_scaler #(.SRC_W(128), .SRC_H(96)) u_dut_b (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .hp(hp), .vp(vp), .mode(mode),
    .out_valid(out_valid_b), .hpos(hpos_b), .vpos(vpos_b), .in_window(in_window_b),
    .line_start(line_start_b), .frame_start(frame_start_b), .seq_err(seq_err_b)
  );

  pixel_scaler #(.SRC_W(100), .SRC_H(240), .SCALE_X(3), .SCALE_Y(1)) u_dut_c (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .hp(hp), .vp(vp), .mode(mode),
    .out_valid(out_valid_c), .hpos(hpos_c), .vpos(vpos_c), .in_window(in_window_c),
    .line_start(line_start_c), .frame_start(frame_start_c), .seq_err(seq_err_c)
  );

  function automatic obs_t act_of(input int k);
    obs_t a;
    a = '0;
    case (k)
      0: begin
        a.ov = out_valid_a; a.hpos = 9'(hpos_a); a.vpos = 9'(vpos_a); a.iw = in_window_a;
        a.ls = line_start_a; a.fs = frame_start_a; a.se = seq_err_a;
      end
      1: begin
        a.ov = out_valid_b; a.hpos = 9'(hpos_b); a.vpos = 9'(vpos_b); a.iw = in_window_b;
        a.ls = line_start_b; a.fs = frame_start_b; a.se = seq_err_b;
      end
      default: begin
        a.ov = out_valid_c; a.hpos = 9'(hpos_c); a.vpos = 9'(vpos_c); a.iw = in_window_c;
        a.ls = line_start_c; a.fs = frame_start_c; a.se = seq_err_c;
      end
    endcase
    return a;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_exp[k] = '0;
    m_synced = 1'b0;
    m_mode   = 1'b0;
    m_seq    = 1'b0;
    m_trust  = 1'b1;
    m_prev   = 0;
  endtask

  // Source pixel = (panel - offset) / scale inside the window, from the raster rules.
  task automatic model_step();
    int h, v, xo, yo;
    logic iw;
    h = int'(hp);
    v = int'(vp);
    if (pix_valid) begin
      if (h == 0 && v == 0) begin
        m_synced = 1'b1;
        m_mode   = mode;
      end
      if (h != 0 && h != m_prev + 1) begin
        m_seq   = 1'b1;
        m_trust = 1'b0;
      end
      if (h == 0) m_trust = 1'b1;
      m_prev = h;
      for (int k = 0; k < 3; k++) begin
        xo = m_mode ? 0 : (320 - cfg_sw[k] * cfg_sx[k]) / 2;
        yo = m_mode ? 0 : (240 - cfg_sh[k] * cfg_sy[k]) / 2;
        iw = m_synced && h >= xo && h < xo + cfg_sw[k] * cfg_sx[k] &&
             v >= yo && v < yo + cfg_sh[k] * cfg_sy[k];
        m_exp[k].ov   = 1'b1;
        m_exp[k].iw   = iw;
        m_exp[k].hpos = iw ? 9'((h - xo) / cfg_sx[k]) : 9'd0;
        m_exp[k].vpos = iw ? 9'((v - yo) / cfg_sy[k]) : 9'd0;
        m_exp[k].ls   = (h == 0);
        m_exp[k].fs   = (h == 0 && v == 0);
        m_exp[k].se   = m_seq;
      end
    end else begin
      for (int k = 0; k < 3; k++) m_exp[k].ov = 1'b0;
    end
    exp_q.push_back({m_trust, m_exp[2], m_exp[1], m_exp[0]});
  endtask

  task automatic sb_check();
    logic [QW-1:0] pk;
    obs_t e, a;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty got=0 want=1");
      return;
    end
    pk = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      e = obs_t'(pk[k*OBS_W +: OBS_W]);
      a = act_of(k);
      if (!pk[QW-1]) begin
        e.hpos = '0;
        a.hpos = '0;
      end
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL sb_dut%0d hp=%0d vp=%0d got ov=%0b hpos=%0d vpos=%0d iw=%0b ls=%0b fs=%0b se=%0b want ov=%0b hpos=%0d vpos=%0d iw=%0b ls=%0b fs=%0b se=%0b",
                 k, hp, vp, a.ov, a.hpos, a.vpos, a.iw, a.ls, a.fs, a.se,
                 e.ov, e.hpos, e.vpos, e.iw, e.ls, e.fs, e.se);
      end
    end
  endtask

  task automatic beat(input logic v, input int h, input int row);
    @(negedge clk);
    pix_valid = v;
    hp        = 9'(h);
    vp        = 8'(row);
    model_step();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    vecs[0]  = '{0, 0,   7,   5,   3,   2, 1};
    vecs[1]  = '{0, 0, 319, 239, 159, 119, 1};
    vecs[2]  = '{1, 0,  31,  24,   0,   0, 0};
    vecs[3]  = '{1, 0,  32,  24,   0,   0, 1};
    vecs[4]  = '{1, 0, 287,  24, 127,   0, 1};
    vecs[5]  = '{1, 0, 288,  24,   0,   0, 0};
    vecs[6]  = '{1, 0,  32, 215,   0,  95, 1};
    vecs[7]  = '{1, 0,  32,  23,   0,   0, 0};
    vecs[8]  = '{2, 0,  10,   0,   0,   0, 1};
    vecs[9]  = '{2, 0,  13,   7,   1,   7, 1};
    vecs[10] = '{2, 0, 309, 239,  99, 239, 1};
    vecs[11] = '{2, 0, 310, 239,   0,   0, 0};
    vecs[12] = '{1, 1,   0,   0,   0,   0, 1};
    vecs[13] = '{1, 1, 255, 191, 127,  95, 1};
    vecs[14] = '{1, 1, 256, 191,   0,   0, 0};

    model_reset();
    do_reset();
    for (int k = 0; k < 3; k++) chk($sformatf("reset_dut%0d", k), int'(act_of(k)), 0);

    // Beats before any frame start must stay outside the window.
    for (int h = 0; h <= 20; h++) beat(1'b1, h, 7);
    chk("presync_iw_a", int'(in_window_a), 0);
    chk("presync_hpos_a", int'(hpos_a), 0);

    for (int i = 0; i < 15; i++) begin
      obs_t a;
      mode = 1'(vecs[i].mode);
      for (int v = 0; v <= vecs[i].vp; v++) begin
        int last;
        last = (v == vecs[i].vp) ? vecs[i].hp : 0;
        for (int h = 0; h <= last; h++) beat(1'b1, h, v);
      end
      a = act_of(vecs[i].dut);
      chk($sformatf("vec%0d_hpos", i), int'(a.hpos), vecs[i].e_hpos);
      chk($sformatf("vec%0d_vpos", i), int'(a.vpos), vecs[i].e_vpos);
      chk($sformatf("vec%0d_iw", i), int'(a.iw), vecs[i].e_iw);
    end

    // Mode change mid-frame waits for the next frame start.
    mode = 1'b0;
    beat(1'b1, 0, 0);
    for (int v = 1; v <= 23; v++) beat(1'b1, 0, v);
    for (int h = 0; h <= 10; h++) beat(1'b1, h, 24);
    mode = 1'b1;
    for (int h = 11; h <= 32; h++) beat(1'b1, h, 24);
    chk("mode_hold_iw_b", int'(in_window_b), 1);
    chk("mode_hold_hpos_b", int'(hpos_b), 0);
    for (int v = 25; v <= 239; v++) beat(1'b1, 0, v);
    beat(1'b1, 0, 0);
    chk("mode_new_iw_b", int'(in_window_b), 1);
    chk("mode_new_hpos_b", int'(hpos_b), 0);
    beat(1'b1, 1, 0);
    beat(1'b1, 2, 0);
    chk("mode_new_hp2_b", int'(hpos_b), 1);
    mode = 1'b0;

    // Reset mid-frame: no window until the next frame start.
    beat(1'b1, 0, 0);
    for (int v = 1; v <= 99; v++) beat(1'b1, 0, v);
    for (int h = 0; h <= 5; h++) beat(1'b1, h, 100);
    chk("pre_rst_iw_a", int'(in_window_a), 1);
    do_reset();
    for (int v = 101; v <= 239; v++) begin
      for (int h = 0; h <= 3; h++) beat(1'b1, h, v);
      chk($sformatf("rst_mid_iw_a_v%0d", v), int'(in_window_a), 0);
    end
    beat(1'b1, 0, 0);
    chk("rst_resync_iw_a", int'(in_window_a), 1);

    // Randomised frames with valid gaps and mode toggles.
    for (int f = 0; f < 2; f++) begin
      for (int v = 0; v <= 239; v++) begin
        int len;
        if ($urandom_range(0, 19) == 0) mode = 1'($urandom_range(0, 1));
        len = ((v % 37) == 0 || $urandom_range(0, 15) == 0) ? 319 : $urandom_range(0, 60);
        for (int h = 0; h <= len; h++) begin
          if ($urandom_range(0, 7) == 0) beat(1'b0, int'(hp), int'(vp));
          beat(1'b1, h, v);
        end
      end
    end
    mode = 1'b0;

    // Sequence monitor: held-hp gaps are fine, a skip is sticky until reset.
    beat(1'b1, 0, 0);
    for (int h = 1; h <= 50; h++) begin
      if (h == 20) begin
        beat(1'b0, 19, 0);
        beat(1'b0, 19, 0);
      end
      beat(1'b1, h, 0);
    end
    chk("seq_gap_a", int'(seq_err_a), 0);
    chk("seq_gap_b", int'(seq_err_b), 0);
    chk("seq_gap_c", int'(seq_err_c), 0);
    beat(1'b1, 52, 0);
    chk("seq_jump_a", int'(seq_err_a), 1);
    chk("seq_jump_b", int'(seq_err_b), 1);
    chk("seq_jump_c", int'(seq_err_c), 1);
    for (int h = 53; h <= 60; h++) beat(1'b1, h, 0);
    beat(1'b0, 60, 0);
    for (int h = 0; h <= 5; h++) beat(1'b1, h, 1);
    chk("seq_sticky_a", int'(seq_err_a), 1);
    do_reset();
    chk("seq_clear_a", int'(seq_err_a), 0);
    chk("seq_clear_c", int'(seq_err_c), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
